// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and instruction-class helpers.
package mips_pkg;

  localparam logic [5:0]  OP_SPECIAL   = 6'h00;
  localparam logic [5:0]  FUNCT_MFHI   = 6'h10;
  localparam logic [5:0]  FUNCT_MTHI   = 6'h11;
  localparam logic [5:0]  FUNCT_MFLO   = 6'h12;
  localparam logic [5:0]  FUNCT_MTLO   = 6'h13;
  localparam logic [5:0]  FUNCT_MULT   = 6'h18;
  localparam logic [5:0]  FUNCT_MULTU  = 6'h19;
  localparam logic [5:0]  FUNCT_DIV    = 6'h1A;
  localparam logic [5:0]  FUNCT_DIVU   = 6'h1B;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;  // sll $0,$0,0

  // R-type field view of an instruction word
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sh;
    logic [5:0] funct;
  } rtype_t;

  // mult/multu/div/divu: occupies the HI/LO unit once it leaves E
  function automatic logic is_md_start(input logic [31:0] w);
    rtype_t i;
    i = rtype_t'(w);
    return (i.op == OP_SPECIAL) &&
           (i.funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
  endfunction

  // mfhi/mthi/mflo/mtlo: touches HI/LO directly
  function automatic logic is_hilo(input logic [31:0] w);
    rtype_t i;
    i = rtype_t'(w);
    return (i.op == OP_SPECIAL) &&
           (i.funct inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO});
  endfunction

  // div/divu select the long busy window
  function automatic logic is_div(input logic [31:0] w);
    rtype_t i;
    i = rtype_t'(w);
    return (i.op == OP_SPECIAL) && (i.funct inside {FUNCT_DIV, FUNCT_DIVU});
  endfunction

endpackage

// File: rtl/instr_pipe_tracker_if.sv
// Fetch/hazard handshake and stage-word bus of the pipeline tracker.
interface instr_pipe_tracker_if;
  logic [31:0] instr_f;
  logic        instr_f_valid;
  logic        hz_stall;
  logic        fetch_ready;
  logic        stall_all;
  logic [31:0] instr_d;
  logic [31:0] instr_e;
  logic [31:0] instr_m;
  logic [31:0] instr_w;
  logic        md_busy;
  logic [3:0]  md_count;

  // fetch / hazard side
  modport master (
    output instr_f, instr_f_valid, hz_stall,
    input  fetch_ready, stall_all, instr_d, instr_e, instr_m, instr_w,
           md_busy, md_count
  );

  // tracker side
  modport slave (
    input  instr_f, instr_f_valid, hz_stall,
    output fetch_ready, stall_all, instr_d, instr_e, instr_m, instr_w,
           md_busy, md_count
  );
endinterface

// File: rtl/instr_pipe_tracker_md_busy_counter.sv
// Multiply/divide busy counter: reloads when an md_start op sits in E,
// otherwise counts down to zero and stays there.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_e,
  input  logic       is_div,
  output logic [3:0] md_count,
  output logic       md_busy
);

  // Count must fit the 4-bit register
  if (MULT_CYCLES < 0 || MULT_CYCLES > 15 || DIV_CYCLES < 0 || DIV_CYCLES > 15) begin : g_bad_cycles
    $error("md_busy_counter: MULT_CYCLES/DIV_CYCLES must be in 0..15");
  end

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  // Reload beats decrement so a newer md_start always restarts the window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                md_count <= '0;
    else if (start_e)          md_count <= is_div ? DIV_LD : MULT_LD;
    else if (md_count != '0)   md_count <= md_count - 4'd1;
  end

  // Busy already in the cycle the op is in E, before the count loads
  assign md_busy = start_e | (md_count != '0);

endmodule

// File: rtl/instr_pipe_tracker.sv
// D/E/M/W instruction-word tracker: feeds the hazard unit, applies its
// stall verdict, and adds the HI/LO interlock from the md busy counter.
module instr_pipe_tracker
  import mips_pkg::*;
#(
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_pipe_tracker_if.slave  bus
);

  logic [31:0] d_q, e_q, m_q, w_q;
  logic        hilo_d, start_e, div_e, md_stall, stall;
  logic [3:0]  cnt;
  logic        busy;

  assign hilo_d   = is_md_start(d_q) | is_hilo(d_q);
  assign start_e  = is_md_start(e_q);
  assign div_e    = is_div(e_q);
  assign md_stall = hilo_d & busy;
  assign stall    = bus.hz_stall | md_stall;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk      (clk),
    .reset    (reset),
    .start_e  (start_e),
    .is_div   (div_e),
    .md_count (cnt),
    .md_busy  (busy)
  );

  // Stage shift; on stall D holds, E takes a bubble, M/W keep draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q <= NOP_WORD;
      e_q <= NOP_WORD;
      m_q <= NOP_WORD;
      w_q <= NOP_WORD;
    end else begin
      w_q <= m_q;
      m_q <= e_q;
      if (stall) begin
        e_q <= NOP_WORD;
      end else begin
        e_q <= d_q;
        d_q <= bus.instr_f_valid ? bus.instr_f : NOP_WORD;
      end
    end
  end

  assign bus.stall_all   = stall;
  assign bus.fetch_ready = ~stall;
  assign bus.instr_d     = d_q;
  assign bus.instr_e     = e_q;
  assign bus.instr_m     = m_q;
  assign bus.instr_w     = w_q;
  assign bus.md_busy     = busy;
  assign bus.md_count    = cnt;

endmodule

// File: tb/tb_instr_pipe_tracker.sv
// Bench for instr_pipe_tracker: directed scenarios plus random traffic,
// every output compared each cycle against a deadline-based model.
module tb_instr_pipe_tracker;
  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [31:0] W_MULT = 32'h0109_0018;
  localparam logic [31:0] W_DIV  = 32'h0109_001A;
  localparam logic [31:0] W_MFLO = 32'h0000_4012;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_pipe_tracker_if bus();

  instr_pipe_tracker #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC),
    .NOP_WORD    (32'h0)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stages as an array (0=D..3=W); md window as an absolute deadline cycle.
  function automatic bit f_md(input logic [31:0] w);
    return (w[31:26] == 6'd0) && (w[5:0] >= 6'h18) && (w[5:0] <= 6'h1B);
  endfunction
  function automatic bit f_hl(input logic [31:0] w);
    return (w[31:26] == 6'd0) && (w[5:0] >= 6'h10) && (w[5:0] <= 6'h13);
  endfunction
  function automatic bit f_dv(input logic [31:0] w);
    return (w[31:26] == 6'd0) && (w[5:0] == 6'h1A || w[5:0] == 6'h1B);
  endfunction

  logic [31:0] ms [4];
  int          cyc, done;
  int          e_cnt;
  bit          e_start, e_busy, e_stall;

  always_comb begin
    e_start = f_md(ms[1]);
    e_cnt   = (done > cyc) ? (done - cyc) : 0;
    e_busy  = e_start || (e_cnt != 0);
    e_stall = bus.hz_stall || ((f_md(ms[0]) || f_hl(ms[0])) && e_busy);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) ms[i] <= 32'h0;
      cyc  <= 0;
      done <= 0;
    end else begin
      if (e_start) done <= cyc + 1 + (f_dv(ms[1]) ? DC : MC);
      ms[3] <= ms[2];
      ms[2] <= ms[1];
      if (e_stall) ms[1] <= 32'h0;
      else begin
        ms[1] <= ms[0];
        ms[0] <= bus.instr_f_valid ? bus.instr_f : 32'h0;
      end
      cyc <= cyc + 1;
    end
  end

  // Per-cycle compare on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("fetch_ready", 32'(bus.fetch_ready), 32'(!e_stall));
      chk("stall_all",   32'(bus.stall_all),   32'(e_stall));
      chk("instr_d",     bus.instr_d, ms[0]);
      chk("instr_e",     bus.instr_e, ms[1]);
      chk("instr_m",     bus.instr_m, ms[2]);
      chk("instr_w",     bus.instr_w, ms[3]);
      chk("md_busy",     32'(bus.md_busy),  32'(e_busy));
      chk("md_count",    32'(bus.md_count), 32'(e_cnt[3:0]));
    end
  end

  // ---------------- stimulus ----------------
  // Present a word until fetch_ready lets it in; returns stall cycles seen.
  task automatic send(input logic [31:0] w, input logic v, input logic hz, output int stalls);
    int n;
    bit ok;
    n = 0; ok = 1'b0; stalls = 0;
    bus.instr_f = w; bus.instr_f_valid = v; bus.hz_stall = hz;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (bus.fetch_ready) ok = 1'b1;
      else stalls++;
      n++;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: word %h not accepted within 40 cycles", w);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {6'd0, r[25:6], 6'h18 + 6'($urandom_range(0, 3))};
      1:       return {6'd0, r[25:6], 6'h10 + 6'($urandom_range(0, 3))};
      2:       return 32'h0;
      3:       return {6'd0, r[25:6], 6'h20};
      default: return {6'h08, r[25:0]};
    endcase
  endfunction

  initial begin
    int s, s2;
    bus.instr_f = 32'h0; bus.instr_f_valid = 1'b0; bus.hz_stall = 1'b0;
    cmp_en = 1'b1;

    // reset state
    #12;
    chk("rst_instr_w", bus.instr_w, 32'h0);
    chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // pure shift A..D
    send(32'h2001_000A, 1, 0, s);
    send(32'h2001_000B, 1, 0, s2); s += s2;
    send(32'h2001_000C, 1, 0, s2); s += s2;
    send(32'h2001_000D, 1, 0, s2); s += s2;
    chk("shift_stalls", 32'(s), 32'h0);
    chk("shift_w", bus.instr_w, 32'h2001_000A);
    chk("shift_m", bus.instr_m, 32'h2001_000B);
    chk("shift_e", bus.instr_e, 32'h2001_000C);
    chk("shift_d", bus.instr_d, 32'h2001_000D);

    // one-cycle hazard stall: D=X, E=Y
    send(32'h2002_0001, 1, 0, s);   // Y
    send(32'h2002_0002, 1, 0, s);   // X
    bus.instr_f = 32'h2002_0003; bus.instr_f_valid = 1'b1; bus.hz_stall = 1'b1;
    @(negedge clk);
    chk("hz_fetch_ready", 32'(bus.fetch_ready), 32'h0);
    @(posedge clk); #1;
    chk("hz_d_hold", bus.instr_d, 32'h2002_0002);
    chk("hz_e_bubble", bus.instr_e, 32'h0);
    chk("hz_m", bus.instr_m, 32'h2002_0001);
    send(32'h2002_0003, 1, 0, s);
    chk("hz_refetch_stalls", 32'(s), 32'h0);
    chk("hz_refetch_d", bus.instr_d, 32'h2002_0003);

    // multiply interlock: mflo held 6 cycles
    send(W_MULT, 1, 0, s);
    send(W_MFLO, 1, 0, s);
    bus.instr_f = 32'h2003_0001; bus.instr_f_valid = 1'b1; bus.hz_stall = 1'b0;
    @(posedge clk); #1;
    chk("mult_count_load", 32'(bus.md_count), 32'd5);
    chk("mult_d_held", bus.instr_d, W_MFLO);
    send(32'h2003_0001, 1, 0, s);
    chk("mult_remaining_stalls", 32'(s), 32'd5);
    chk("mflo_to_e", bus.instr_e, W_MFLO);

    // divide, then a later mult restarts the count at 5
    send(W_DIV, 1, 0, s);
    send(32'h2004_0001, 1, 0, s);
    send(32'h2004_0002, 1, 0, s);
    send(W_MULT, 1, 0, s);
    send(32'h2004_0003, 1, 0, s);
    chk("div_mult_stalls", 32'(s), 32'd9);
    chk("div_mult_in_e", bus.instr_e, W_MULT);
    bus.instr_f = 32'h2004_0004;
    @(posedge clk); #1;
    chk("mult_reload", 32'(bus.md_count), 32'd5);
    send(32'h2004_0004, 1, 0, s);

    // invalid fetch: two bubbles, no stall
    send(32'h2005_0001, 1, 0, s);
    send(32'hDEAD_BEEF, 0, 0, s2); s += s2;
    send(32'hDEAD_BEEF, 0, 0, s2); s += s2;
    send(32'h2005_0002, 1, 0, s2); s += s2;
    chk("inv_stalls", 32'(s), 32'h0);
    chk("inv_d", bus.instr_d, 32'h2005_0002);
    chk("inv_e", bus.instr_e, 32'h0);
    chk("inv_m", bus.instr_m, 32'h0);
    chk("inv_w", bus.instr_w, 32'h2005_0001);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.instr_f       = rnd_word();
      bus.instr_f_valid = ($urandom_range(0, 4) != 0);
      bus.hz_stall      = ($urandom_range(0, 5) == 0);
      @(posedge clk); #1;
    end

    // asynchronous reset with the divider counting
    send(W_DIV, 1, 0, s);
    send(32'h2006_0001, 1, 0, s);
    send(32'h2006_0002, 1, 0, s);
    chk("pre_rst_count", 32'(bus.md_count), 32'd10);
    bus.hz_stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d", bus.instr_d, 32'h0);
    chk("arst_e", bus.instr_e, 32'h0);
    chk("arst_count", 32'(bus.md_count), 32'h0);
    chk("arst_busy", 32'(bus.md_busy), 32'h0);
    chk("arst_stall_all", 32'(bus.stall_all), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(32'h2007_0001, 1, 0, s);
    send(32'h2007_0002, 1, 0, s);
    chk("post_rst_d", bus.instr_d, 32'h2007_0002);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
